// File: rtl/fpga_template_pkg.sv
// Shared widths, FSM state type and the saturation helper for the sample conditioner.
package fpga_template_pkg;

    localparam int SAMPLE_W = 24;
    localparam int RAM_W    = 32;
    localparam int GAIN_W   = 3;
    // DC-removed sample carries one extra bit so x - dc never wraps.
    localparam int HP_W     = SAMPLE_W + 1;
    // Widest left shift (7) applied to the high-pass word.
    localparam int G_W      = HP_W + (1 << GAIN_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        GAIN = 2'd2,
        WAIT = 2'd3
    } cond_state_t;

    typedef struct packed {
        logic                clip;
        logic [SAMPLE_W-1:0] value;
    } sat_t;

    // Clamp a gained word to signed SAMPLE_W bits; clip flags any clamping.
    function automatic sat_t saturate(input logic signed [G_W-1:0] g);
        sat_t                  r;
        logic [G_W-SAMPLE_W:0] top;
        top    = g[G_W-1:SAMPLE_W-1];
        r.clip = !((&top) || !(|top));
        if (r.clip) begin
            r.value = g[G_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                               : {1'b0, {(SAMPLE_W-1){1'b1}}};
        end else begin
            r.value = g[SAMPLE_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_conditioner_if.sv
// Write-side handshake bundle between the conditioner and the RAM write port.
interface sample_conditioner_if
    import fpga_template_pkg::*;
    ();

    logic [RAM_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sample_dc_filter.sv
// Leaky-integrator DC estimator: hp = x - (acc >>> K), acc tracks x * 2^K.
module sample_dc_filter
    import fpga_template_pkg::*;
#(
    parameter int K = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                update_i,
    input  logic                bypass_i,
    input  logic [SAMPLE_W-1:0] x_i,
    output logic [HP_W-1:0]     hp_o
);

    localparam int ACC_W = SAMPLE_W + K;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] dc;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] hp_full;

    // DC estimate, high-pass difference and the next accumulator value.
    always_comb begin
        dc      = acc_q >>> K;
        x_ext   = {{(ACC_W-SAMPLE_W){x_i[SAMPLE_W-1]}}, x_i};
        hp_full = x_ext - dc;
        acc_d   = acc_q;
        if (bypass_i) begin
            hp_o = {x_i[SAMPLE_W-1], x_i};
        end else begin
            hp_o = hp_full[HP_W-1:0];
            if (update_i) begin
                acc_d = acc_q + hp_full;
            end
        end
    end

    // Accumulator register; frozen whenever bypass is selected.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sample_conditioner.sv
// DC removal, saturating power-of-two gain and valid/ready write toward RAM.
module sample_conditioner
    import fpga_template_pkg::*;
#(
    parameter int DC_SHIFT = 10,
    parameter int DROP_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                sample_valid_i,
    input  logic [GAIN_W-1:0]   gain_shift_i,
    input  logic                bypass_i,
    output logic [RAM_W-1:0]    data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                clip_o,
    output logic [DROP_W-1:0]   drop_count_o
);

    cond_state_t         state_q, state_d;
    logic [SAMPLE_W-1:0] x_q, x_d;
    logic [GAIN_W-1:0]   gain_q, gain_d;
    logic                bypass_q, bypass_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [SAMPLE_W-1:0] result_q, result_d;
    logic                valid_q, valid_d;
    logic                clip_q, clip_d;
    logic [DROP_W-1:0]   drop_q, drop_d;

    logic [HP_W-1:0]       hp_filt;
    logic signed [G_W-1:0] gained;
    sat_t                  sat;

    sample_dc_filter #(
        .K (DC_SHIFT)
    ) u_dc (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .update_i (state_q == CALC),
        .bypass_i (bypass_q),
        .x_i      (x_q),
        .hp_o     (hp_filt)
    );

    // Gain stage works on the registered high-pass word.
    always_comb begin
        gained = $signed({{(G_W-HP_W){hp_q[HP_W-1]}}, hp_q}) <<< gain_q;
        sat    = saturate(gained);
    end

    // Next-state and output logic; busy-state pulses only bump the drop counter.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        gain_d   = gain_q;
        bypass_d = bypass_q;
        hp_d     = hp_q;
        result_d = result_q;
        valid_d  = valid_q;
        clip_d   = 1'b0;
        drop_d   = drop_q;
        case (state_q)
            IDLE: begin
                if (sample_valid_i) begin
                    x_d      = sample_i;
                    gain_d   = gain_shift_i;
                    bypass_d = bypass_i;
                    state_d  = CALC;
                end
            end
            CALC: begin
                hp_d    = hp_filt;
                state_d = GAIN;
            end
            GAIN: begin
                result_d = sat.value;
                clip_d   = sat.clip;
                valid_d  = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ready_i) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (sample_valid_i && (state_q != IDLE) && (drop_q != {DROP_W{1'b1}})) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // FSM and registered outputs; reset discards any pending word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            x_q      <= '0;
            gain_q   <= '0;
            bypass_q <= 1'b0;
            hp_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            clip_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            gain_q   <= gain_d;
            bypass_q <= bypass_d;
            hp_q     <= hp_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            clip_q   <= clip_d;
            drop_q   <= drop_d;
        end
    end

    assign data_o       = {{(RAM_W-SAMPLE_W){1'b0}}, result_q};
    assign valid_o      = valid_q;
    assign clip_o       = clip_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_sample_conditioner.sv
// Randomized bench for sample_conditioner against an arithmetic reference model.
module tb_sample_conditioner;

    localparam int K     = 4;
    localparam int DW    = 4;

    logic        clk;
    logic        rst_n;
    logic [23:0] sample;
    logic        sample_valid;
    logic [2:0]  gain;
    logic        bypass;
    logic        clip;
    logic [DW-1:0] drop;

    int total = 0;
    int bad   = 0;
    longint model_acc = 0;

    sample_conditioner_if bus ();

    sample_conditioner #(
        .DC_SHIFT (K),
        .DROP_W   (DW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .sample_i       (sample),
        .sample_valid_i (sample_valid),
        .gain_shift_i   (gain),
        .bypass_i       (bypass),
        .data_o         (bus.data),
        .valid_o        (bus.valid),
        .ready_i        (bus.ready),
        .clip_o         (clip),
        .drop_count_o   (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: floor(acc / 2^K) as DC estimate, integer gain, clamp to 24 bits.
    task automatic model(input logic [23:0] x, input int g, input bit b,
                         output logic [31:0] d, output bit c);
        longint xs, dc, hp, gv, div;
        xs  = $signed(x);
        div = longint'(1) << K;
        if (b) begin
            hp = xs;
        end else begin
            if (model_acc >= 0) dc = model_acc / div;
            else                dc = -((-model_acc + div - 1) / div);
            hp = xs - dc;
            model_acc = model_acc + hp;
        end
        gv = hp * (longint'(1) << g);
        c  = 1'b0;
        if (gv > 8388607)       begin gv = 8388607;  c = 1'b1; end
        else if (gv < -8388608) begin gv = -8388608; c = 1'b1; end
        d = {8'h00, gv[23:0]};
    endtask

    // One-cycle sample pulse; returns #1 after the accepting edge.
    task automatic pulse(input logic [23:0] x, input int g, input bit b);
        sample       = x;
        gain         = 3'(g);
        bypass       = b;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Full transaction: pulse, check latency/data/clip, hold ready low 'hold' cycles.
    task automatic run_one(input logic [23:0] x, input int g, input bit b, input int hold,
                           output logic [31:0] got);
        logic [31:0] exp_d;
        bit          exp_c;
        int          n;
        model(x, g, b, exp_d, exp_c);
        bus.ready = (hold == 0);
        pulse(x, g, b);
        wait_valid(n);
        chk("latency", n, 2);
        chk("data", bus.data, exp_d);
        chk("clip", clip, exp_c);
        got = bus.data;
        $display("txn x=%06h g=%0d b=%0d data=%08h clip=%0b", x, g, b, bus.data, clip);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.valid, 1);
            chk("hold_data", bus.data, exp_d);
            chk("hold_clip", clip, 0);
        end
        bus.ready = 1'b1;
        @(posedge clk); #1;
        chk("handshake", bus.valid, 0);
        chk("clip_clear", clip, 0);
    endtask

    initial begin
        logic [31:0] got, held;
        logic [23:0] x;
        int          n, mag;
        rst_n        = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        gain         = '0;
        bypass       = 1'b0;
        bus.ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.valid, 0);
        chk("rst_data", bus.data, 0);
        chk("rst_clip", clip, 0);
        chk("rst_drop", drop, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant step into the DC filter; output must decay toward zero.
        for (int i = 0; i < 200; i++) begin
            run_one(24'h100000, 0, 1'b0, 0, got);
            if (i == 0) chk("step_first", got, 32'h00100000);
            if (i == 1) chk("step_second", got, 32'h000F0000);
        end
        mag = $signed(got[23:0]);
        if (mag < 0) mag = -mag;
        chk("dc_settled", (mag <= 16), 1);

        // Bypass saturation corners and small-gain exact case.
        run_one(24'h200000, 3, 1'b1, 0, got);
        chk("sat_pos", got, 32'h007FFFFF);
        run_one(24'hE00000, 3, 1'b1, 0, got);
        chk("sat_neg", got, 32'h00800000);
        run_one(24'h000100, 2, 1'b1, 0, got);
        chk("gain2", got, 32'h00000400);

        // Random samples, gains, bypass and ready back-pressure.
        for (int i = 0; i < 60; i++) begin
            x = 24'($urandom);
            run_one(x, int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), got);
        end

        // Back-pressure with dropped pulses.
        chk("drop_before", drop, 0);
        begin
            logic [31:0] exp_d;
            bit          exp_c;
            model(24'h012345, 1, 1'b1, exp_d, exp_c);
            bus.ready = 1'b0;
            pulse(24'h012345, 1, 1'b1);
            wait_valid(n);
            chk("bp_latency", n, 2);
            chk("bp_data", bus.data, exp_d);
            held = bus.data;
            for (int i = 0; i < 3; i++) begin
                pulse(24'($urandom), 5, 1'b0);
                @(posedge clk); #1;
                chk("bp_valid", bus.valid, 1);
                chk("bp_held", bus.data, held);
            end
            chk("drop3", drop, 3);
            bus.ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_release", bus.valid, 0);
            run_one(24'h000010, 0, 1'b1, 0, got);
            chk("drop_after", drop, 3);
        end

        // Drop counter saturation.
        begin
            logic [31:0] exp_d;
            bit          exp_c;
            model(24'h000001, 0, 1'b1, exp_d, exp_c);
            bus.ready = 1'b0;
            pulse(24'h000001, 0, 1'b1);
            wait_valid(n);
            chk("sat_cnt_data", bus.data, exp_d);
            for (int i = 0; i < 20; i++) begin
                pulse(24'h0, 0, 1'b1);
            end
            chk("drop_sat", drop, 15);
            chk("sat_cnt_valid", bus.valid, 1);
            bus.ready = 1'b1;
            @(posedge clk); #1;
            chk("sat_cnt_hs", bus.valid, 0);
        end

        // Asynchronous reset while waiting for ready.
        begin
            logic [31:0] exp_d;
            bit          exp_c;
            model(24'h0ABCDE, 0, 1'b0, exp_d, exp_c);
            bus.ready = 1'b0;
            pulse(24'h0ABCDE, 0, 1'b0);
            wait_valid(n);
            chk("pre_rst_valid", bus.valid, 1);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("async_valid", bus.valid, 0);
            chk("async_data", bus.data, 0);
            chk("async_drop", drop, 0);
            chk("async_acc", 64'(dut.u_dc.acc_q), 0);
            model_acc = 0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk); #1;
            run_one(24'h0ABCDE, 0, 1'b0, 0, got);
            chk("post_rst_raw", got, 32'h000ABCDE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_conditioner.md
SAMPLE_CONDITIONER -- requirements
Module: sample_conditioner

Sits between i2s_capture_24 (left channel) and ram_logic write port. It removes DC, applies a saturating power-of-two gain, and drives a valid/ready write handshake.

Interface
REQ-001 SHALL have parameter DC_SHIFT, default 10, DC-tracking leak shift K (valid range 2..16).
REQ-002 SHALL have parameter DROP_W, default 16, width of the drop counter.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sample_i, input, 24, signed PCM sample from the sampler.
REQ-006 SHALL have port sample_valid_i, input, 1, single-cycle pulse qualifying sample_i.
REQ-007 SHALL have port gain_shift_i, input, 3, left-shift amount 0..7 applied after DC removal.
REQ-008 SHALL have port bypass_i, input, 1, when 1 DC removal is skipped and the accumulator is frozen.
REQ-009 SHALL have port data_o, output, 32, RAM word {8'b0, result[23:0]}.
REQ-010 SHALL have port valid_o, output, 1, data_o valid toward ram_logic write_valid_i.
REQ-011 SHALL have port ready_i, input, 1, RAM accepts the word (write_ready_o).
REQ-012 SHALL have port clip_o, output, 1, one-cycle pulse when the result saturated.
REQ-013 SHALL have port drop_count_o, output, DROP_W, saturating count of discarded samples.

Function
REQ-014 FSM states SHALL be IDLE, CALC, GAIN, WAIT.
REQ-015 IDLE->CALC on sample_valid_i; sample_i, gain_shift_i and bypass_i are registered on that edge.
REQ-016 CALC: dc = acc >>> K (arithmetic); hp = x - dc in 25 bits; acc <= acc + x - dc, with acc signed 24+K bits; if bypass, hp = sign-extended x and acc unchanged. CALC->GAIN unconditionally.
REQ-017 GAIN: g = hp <<< gain_shift; saturate to signed 24 bits (max 0x7FFFFF, min 0x800000); register data_o; valid_o <= 1; clip_o pulses 1 cycle if saturated. GAIN->WAIT.
REQ-018 WAIT: valid_o and data_o held stable until a cycle with ready_i=1; on that edge valid_o <= 0 and next state is IDLE.
REQ-019 Latency: pulse at cycle n in IDLE gives valid_o high from cycle n+2; minimum sample spacing without drop is 3 cycles plus handshake wait.
REQ-020 sample_valid_i in CALC, GAIN or WAIT SHALL discard the sample, leave the pipeline untouched, and increment drop_count_o, saturating at all-ones.
REQ-021 A sample_valid_i in the same cycle as the WAIT->IDLE handshake SHALL be dropped; acceptance occurs only in IDLE.
REQ-022 valid_o SHALL never deassert without a handshake, and data_o SHALL never change while valid_o=1.
REQ-023 clip_o SHALL be 0 outside the GAIN->WAIT edge.

Reset
REQ-024 On rst_ni low, asynchronously: state IDLE, acc 0, data_o 0, valid_o 0, clip_o 0, drop_count_o 0; any pending word is discarded.
REQ-025 After rst_ni deasserts, the first sample_valid_i SHALL be accepted normally.

Structure
REQ-026 fpga_template_pkg SHALL hold SAMPLE_W=24, RAM_W=32, and the state enum type cond_state_t.
REQ-027 The DC estimator (acc register, dc/hp arithmetic, bypass freeze) SHALL be one sub-module, sample_dc_filter; gain, saturation, FSM and handshake stay in the top.

Verification
REQ-028 With K=4, gain 0, bypass 0, the input is constant 0x100000 every 100 cycles with ready_i=1. The first data_o SHALL be 0x00100000, the next 0x000F0000. |result| SHALL be <=16 after 200 samples.
REQ-029 With bypass 1, gain 3, sample 0x200000, the result SHALL be 0x007FFFFF with a clip_o pulse. Sample 0xE00000 SHALL give 0x00800000 with a clip_o pulse.
REQ-030 With bypass 1, gain 2, sample 0x000100, the result SHALL be 0x00000400 with no clip. valid_o SHALL rise exactly 2 cycles after the pulse.
REQ-031 Hold ready_i=0 after one sample and send 3 more pulses. valid_o SHALL stay 1, data_o SHALL be unchanged, drop_count_o SHALL be 3. When ready_i is raised, one handshake occurs and the state returns to IDLE.
REQ-032 With DROP_W=4, send 20 dropped pulses: drop_count_o SHALL stay at 15.
REQ-033 Assert rst_ni low in WAIT mid-cycle: valid_o, data_o and acc SHALL clear immediately, with no clock needed. The next sample after release SHALL output x unfiltered, the acc=0 case.
